// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: buffers an incoming pixel/valid stream in a small FIFO
// and writes exactly one frame of pixels to sequential frame-memory addresses,
// pulsing frame_done after the last write has been granted.
// Optional feature macro: PIXEL_CHECKSUM_EN (adds a running 32-bit pixel sum).
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for start; nothing accepted, FIFO empty
// RUN     | accepting pixels until FRAME_PIXELS have been pushed
// DRAIN   | all pixels accepted; flushing remaining FIFO entries to memory
module pixel_frame_writer #(
    parameter int FRAME_PIXELS = 65536,
    parameter int ADDR_W       = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [23:0]       pixel_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic              mem_gnt,
    output logic              frame_done,
    output logic [ADDR_W:0]   pixel_cnt,
    output logic [31:0]       checksum
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(FRAME_PIXELS);
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [PTR_W:0]    LVL_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    LVL_ONE   = (PTR_W+1)'(1);

    logic [1:0]        state;
    logic [23:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_level;
    logic [ADDR_W-1:0] wr_addr;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic start_frame;
    logic last_push;
    logic last_pop;

    assign fifo_full   = (fifo_level == LVL_FULL);
    assign fifo_empty  = (fifo_level == '0);

    // ready depends only on registered state, never on valid_in
    assign ready_out   = (state == S_RUN) && !fifo_full && (pixel_cnt < CNT_FULL);
    assign push        = valid_in && ready_out;

    assign mem_we      = !fifo_empty;
    assign mem_addr    = wr_addr;
    assign mem_wdata   = fifo_mem[rd_ptr];
    assign pop         = mem_we && mem_gnt;

    assign start_frame = (state == S_IDLE) && start;
    assign last_push   = push && (pixel_cnt == CNT_LAST);
    // nothing is pushed in DRAIN, so level 1 plus a pop empties the FIFO
    assign last_pop    = (state == S_DRAIN) && pop && (fifo_level == LVL_ONE);

    // frame sequencing and the registered end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pop;
            case (state)
                S_IDLE:  if (start)     state <= S_RUN;
                S_RUN:   if (last_push) state <= S_DRAIN;
                S_DRAIN: if (last_pop)  state <= S_IDLE;
                default:                state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage and pointers; storage is cleared so mem_wdata resets to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= pixel_in;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // accepted-pixel count and write address, both restarted on frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_cnt <= '0;
            wr_addr   <= '0;
        end else if (start_frame) begin
            pixel_cnt <= '0;
            wr_addr   <= '0;
        end else begin
            if (push && (pixel_cnt < CNT_FULL)) begin
                pixel_cnt <= pixel_cnt + (ADDR_W+1)'(1);
            end
            // hold at the last address so the counter never wraps mid-frame
            if (pop && (wr_addr != ADDR_LAST)) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

`ifdef PIXEL_CHECKSUM_EN
    logic [31:0] csum;

    // running sum of accepted pixels, held after the frame until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (start_frame) begin
            csum <= '0;
        end else if (push) begin
            csum <= csum + {8'd0, pixel_in};
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Self-checking bench for pixel_frame_writer (256-pixel frames, 4-deep FIFO).
// The reference model is the ordered list of pixels the handshake accepted:
// write k must go to address k carrying the k-th accepted pixel.
module tb_pixel_frame_writer;

    localparam int FP    = 256;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [23:0]   pixel_in;
    logic          valid_in;
    logic          ready_out;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          mem_gnt;
    logic          frame_done;
    logic [AW:0]   pixel_cnt;
    logic [31:0]   checksum;

    pixel_frame_writer #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pixel_in   (pixel_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .frame_done (frame_done),
        .pixel_cnt  (pixel_cnt),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] acc_q[$];
    int          wr_idx = 0;
    int          done_cnt = 0;
    bit          prev_final = 0;
    bit          stall_prev = 0;
    logic [AW-1:0] stall_addr;
    logic [23:0] stall_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum();
        logic [31:0] s = '0;
`ifdef PIXEL_CHECKSUM_EN
        foreach (acc_q[i]) s += {8'd0, acc_q[i]};
`endif
        return s;
    endfunction

    // edge monitor: records accepts, checks each write, stall stability and frame_done timing
    always @(posedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
            prev_final = 0;
        end else begin
            if (frame_done) begin
                done_cnt++;
                check("done_after_last_write", prev_final, 1'b1);
                check("done_ready_low", ready_out, 1'b0);
            end
            if (stall_prev) begin
                check("stall_addr", mem_addr, stall_addr);
                check("stall_data", mem_wdata, stall_data);
            end
            prev_final = 0;
            if (mem_we && mem_gnt) begin
                if (wr_idx < acc_q.size()) begin
                    check("wr_addr", mem_addr, wr_idx);
                    check("wr_data", mem_wdata, acc_q[wr_idx]);
                end else begin
                    check("wr_unexpected", wr_idx, acc_q.size());
                end
                prev_final = (wr_idx == FP - 1);
                wr_idx++;
            end
            stall_prev = mem_we && !mem_gnt;
            stall_addr = mem_addr;
            stall_data = mem_wdata;
            if (valid_in && ready_out) begin
                if (acc_q.size() < FP) acc_q.push_back(pixel_in);
                else check("accept_overflow", acc_q.size(), FP - 1);
            end
        end
    end

    // pv/pg: valid and grant probability in percent; stray: pulse start in RUN and DRAIN
    task automatic run_frame(input int pv, input int pg, input bit stray, input bit do_start);
        int cyc = 0;
        int d0 = done_cnt;
        bit drain_start = 0;
        if (do_start) begin
            acc_q.delete();
            wr_idx = 0;
            check("idle_ready", ready_out, 1'b0);
            start = 1'b1;
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            check("ready_after_start", ready_out, 1'b1);
        end
        while (done_cnt == d0 && cyc < 4000) begin
            valid_in = ($urandom_range(99) < pv);
            pixel_in = 24'($urandom());
            mem_gnt  = ($urandom_range(99) < pg);
            start    = 1'b0;
            if (stray) begin
                if (cyc == 5) start = 1'b1;
                if (acc_q.size() == FP && !drain_start) begin
                    mem_gnt = 1'b0;
                    start = 1'b1;
                    drain_start = 1;
                end
            end
            @(posedge clk); @(negedge clk);
            check("pixel_cnt", pixel_cnt, acc_q.size());
            cyc++;
        end
        start = 1'b0;
        valid_in = 1'b0;
        if (do_start && pv == 100 && pg == 100) check("full_rate_cycles", cyc, FP + 2);
        check("frame_done_once", done_cnt, d0 + 1);
        check("writes", wr_idx, FP);
        check("accepted", acc_q.size(), FP);
        check("pixel_cnt_end", pixel_cnt, FP);
        check("checksum", checksum, exp_sum());
        valid_in = 1'b1;
        mem_gnt = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("post_ready", ready_out, 1'b0);
            check("post_we", mem_we, 1'b0);
        end
        valid_in = 1'b0;
        check("done_quiet", done_cnt, d0 + 1);
        check("checksum_hold", checksum, exp_sum());
        check("pixel_cnt_hold", pixel_cnt, FP);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready_out, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, '0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_done"}, frame_done, 1'b0);
        check({tag, "_cnt"}, pixel_cnt, '0);
        check({tag, "_csum"}, checksum, '0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        pixel_in = '0;
        valid_in = 1'b0;
        mem_gnt = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_ready", ready_out, 1'b0);

        // full-rate frame, then random valid/grant gaps
        run_frame(100, 100, 0, 1);
        run_frame(50, 50, 0, 1);

        // back-pressure: grant withheld for 10 cycles while valid stays high
        acc_q.delete();
        wr_idx = 0;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        valid_in = 1'b1;
        mem_gnt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pixel_in = 24'($urandom());
            @(posedge clk); @(negedge clk);
        end
        check("bp_accepted", acc_q.size(), DEPTH);
        check("bp_ready", ready_out, 1'b0);
        check("bp_we", mem_we, 1'b1);
        check("bp_addr", mem_addr, '0);
        check("bp_wdata", mem_wdata, acc_q[0]);
        run_frame(100, 100, 0, 0);

        // stray start pulses in RUN and DRAIN
        run_frame(70, 60, 1, 1);

        // reset after 100 accepted pixels
        acc_q.delete();
        wr_idx = 0;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (acc_q.size() < 100 && cyc < 2000) begin
            valid_in = 1'b1;
            pixel_in = 24'($urandom());
            mem_gnt = ($urandom_range(99) < 50);
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check("pre_reset_accepted", acc_q.size(), 100);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        acc_q.delete();
        wr_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_gnt = 1'b1;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            check("after_reset_we", mem_we, 1'b0);
            check("after_reset_ready", ready_out, 1'b0);
        end
        valid_in = 1'b0;
        run_frame(100, 100, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
# pixel_frame_writer

Stream-to-memory sink at the output end of the pixel-filter pipeline. It accepts the `pixel` / `valid` stream produced by a filter stage such as the negative-film block and buffers it in a small FIFO. It then writes one frame of pixels into a frame memory at sequential addresses and pulses `frame_done` once the last pixel is committed. Filter stages feed it; it drives the frame-buffer SRAM write port.

## Interface
- `FRAME_PIXELS`, 65536: pixels per frame (256x256).
- `ADDR_W`, 16: memory address width; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- `FIFO_DEPTH`, 4: input buffer entries; power of two, >= 2.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `pixel_in`  in  24  RGB pixel, {R,G,B}.
- `valid_in`  in  1  `pixel_in` is valid.
- `ready_out`  out  1  block can accept a pixel this cycle.
- `mem_we`  out  1  write request.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  24  write data.
- `mem_gnt`  in  1  memory accepts the write this cycle.
- `frame_done`  out  1  one-cycle pulse after the final write of a frame.
- `pixel_cnt`  out  ADDR_W+1  pixels accepted in the current frame.
- `checksum`  out  32  frame checksum; only meaningful with `PIXEL_CHECKSUM_EN`.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE -> RUN when `start`=1. Entering RUN clears `pixel_cnt`, the write address and `checksum`.
  - RUN -> DRAIN on the edge where accepted pixel number FRAME_PIXELS is pushed.
  - DRAIN -> IDLE on the edge where the last FIFO entry is written. `frame_done`=1 for that next cycle only.
  - `start` in RUN or DRAIN is ignored.
- **Input handshake:** a pixel is accepted on an edge where `valid_in && ready_out`.
  - `ready_out` = (state==RUN) && !fifo_full && (`pixel_cnt` < FRAME_PIXELS).
  - `ready_out` is combinational from registered state only; it never depends on `valid_in`.
- **Memory handshake:**
  - `mem_we` = FIFO not empty, in any state.
  - `mem_wdata` = FIFO head.
  - `mem_addr` = write counter.
  - A write completes on an edge where `mem_we && mem_gnt`. The FIFO then pops and the write counter increments.
  - `mem_wdata` and `mem_addr` are held stable while `mem_we`=1 and `mem_gnt`=0.
- **FIFO:** push and pop in the same cycle are allowed. When full, `ready_out`=0, so there is no bypass-on-pop.
- **Counters:** the write counter runs 0..FRAME_PIXELS-1 and never wraps within a frame. `pixel_cnt` saturates at FRAME_PIXELS.
- **Data integrity:** pixels are written unmodified, in arrival order.

## Timing
- **Reset values (asynchronous):** state=IDLE, FIFO empty. All outputs 0: `ready_out`, `mem_we`, `mem_addr`, `mem_wdata`, `frame_done`, `pixel_cnt`, `checksum`.
- **Reset mid-frame:** the frame is abandoned and the FIFO is flushed. No `frame_done` is issued, and no write is issued until after the next `start`.
- **Start to ready:** `ready_out` rises the cycle after the `start` edge.
- **Accept to write:** with `mem_gnt` held 1, a pixel accepted at edge N drives `mem_we`=1 in cycle N+1 and completes at edge N+1. Sustained throughput is 1 pixel per clock.
- **Frame end:** `frame_done` is high for the single cycle following the last write-completion edge. `ready_out` is 0 in that cycle.

## Configuration
- `PIXEL_CHECKSUM_EN` defined:
  - `checksum` accumulates, mod 2^32, the zero-extended 24-bit value of every pixel as it is accepted.
  - It is cleared on entry to RUN and holds its value through IDLE after the frame.
- `PIXEL_CHECKSUM_EN` undefined:
  - `checksum` is tied to 0 and no accumulator is synthesized.
  - All other behaviour is identical.

## Test plan
- **Full frame:** `start`, then 65536 pixels with `valid_in`=1 and `mem_gnt`=1 every cycle -> addresses 0..65535 are written with data equal to the input, `frame_done` pulses exactly once one cycle after the last write, and `pixel_cnt`=65536.
- **Back-pressure:** `mem_gnt`=0 for 10 cycles while `valid_in`=1 -> exactly 4 pixels are accepted, then `ready_out`=0. `mem_addr` and `mem_wdata` stay stable. After `mem_gnt`=1 returns, all pixels land in order with no loss or duplication.
- **Valid gaps:** random `valid_in` (50%) and random `mem_gnt` (50%) over a FRAME_PIXELS=16 frame -> memory image matches the input sequence and `frame_done` pulses once.
- **Stray start:** `start` pulsed in IDLE, in RUN and in DRAIN -> only the IDLE pulse starts a frame. `pixel_cnt` is not cleared by the RUN or DRAIN pulses.
- **Reset mid-frame:** `rst_n`=0 after 100 accepted pixels -> all outputs 0 immediately and `mem_we` stays 0. A following `start` plus 16 pixels writes from address 0.
- **Checksum (`PIXEL_CHECKSUM_EN`):** FRAME_PIXELS=3 with pixels 0xFFFFFF, 0xFFFFFF, 0x000002 -> `checksum`=0x02000000. With the macro undefined -> `checksum`=0.
